// File: rtl/instruction_buffer.sv
// ============================================================================
// instruction_buffer
// ----------------------------------------------------------------------------
// Per-warp instruction FIFO sitting between the decoder and the issue stage.
// Each warp tracks three counters:
//   reserved : fetches handed to the icache whose decode has not returned yet
//   occ      : decoded entries waiting in this warp's FIFO
//   inflight : instructions issued but not yet written back
// The fetcher is told a warp has space only when reserved+occ leaves room for
// one more entry, so it can never over-fetch.  A warp is reported finished only
// when all three counters are zero.
//
// Optional feature (macro IB_BYPASS_EN):
//   When a warp's FIFO is empty and it may still issue, a decoded instruction
//   for that warp is presented on the dispatch port in the same cycle.  If the
//   issue stage takes it right away it is never stored.  With the macro
//   undefined there is no combinational path from dec_* to disp_*.
//
// Ports:
//   clk_i                   clock
//   rst_i                   synchronous active-high reset
//   fe_handshake_i          fetch accepted by the icache this cycle
//   fe_warp_id_i            warp of that fetch
//   dec_valid_i             decoder delivers an instruction
//   dec_discard_i           decoder consumed a fetch without producing an entry
//   dec_warp_id_i           warp for dec_valid_i / dec_discard_i
//   dec_data_i              decoded payload
//   ib_space_available_o    per warp: a new fetch may be issued
//   ib_all_instr_finished_o per warp: nothing reserved, buffered or in flight
//   disp_valid_o            per warp: head entry valid and issuable
//   disp_data_o             per warp: head payload (warp w at [w*DataWidth +: DataWidth])
//   disp_ready_i            per warp: issue stage accepts the head entry
//   wb_valid_i              one instruction completed writeback
//   wb_warp_id_i            warp of that completion
// ============================================================================
module instruction_buffer #(
    parameter int NumWarps    = 8,
    parameter int IbDepth     = 2,
    parameter int MaxInflight = 4,
    parameter int DataWidth   = 64,
    parameter int WidWidth    = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          fe_handshake_i,
    input  logic [WidWidth-1:0]           fe_warp_id_i,
    input  logic                          dec_valid_i,
    input  logic                          dec_discard_i,
    input  logic [WidWidth-1:0]           dec_warp_id_i,
    input  logic [DataWidth-1:0]          dec_data_i,
    output logic [NumWarps-1:0]           ib_space_available_o,
    output logic [NumWarps-1:0]           ib_all_instr_finished_o,
    output logic [NumWarps-1:0]           disp_valid_o,
    output logic [NumWarps*DataWidth-1:0] disp_data_o,
    input  logic [NumWarps-1:0]           disp_ready_i,
    input  logic                          wb_valid_i,
    input  logic [WidWidth-1:0]           wb_warp_id_i
);

    localparam int CntWidth = $clog2(IbDepth + 1);
    localparam int InfWidth = $clog2(MaxInflight + 1);
    localparam int PtrWidth = (IbDepth > 1) ? $clog2(IbDepth) : 1;

    localparam logic [CntWidth:0]     DepthVal  = (CntWidth + 1)'(IbDepth);
    localparam logic [InfWidth-1:0]   MaxInfVal = InfWidth'(MaxInflight);
    localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(IbDepth - 1);

    logic [CntWidth-1:0]  r_reserved [NumWarps];
    logic [CntWidth-1:0]  r_occ      [NumWarps];
    logic [InfWidth-1:0]  r_inflight [NumWarps];
    logic [PtrWidth-1:0]  r_rdPtr    [NumWarps];
    logic [PtrWidth-1:0]  r_wrPtr    [NumWarps];
    logic [DataWidth-1:0] r_mem      [NumWarps][IbDepth];

    logic [NumWarps-1:0]  w_feHit;
    logic [NumWarps-1:0]  w_decHit;
    logic [NumWarps-1:0]  w_discHit;
    logic [NumWarps-1:0]  w_wbHit;
    logic [NumWarps-1:0]  w_canIssue;
    logic [NumWarps-1:0]  w_dispFire;
    logic [NumWarps-1:0]  w_store;
    logic [NumWarps-1:0]  w_pop;
    logic [DataWidth-1:0] w_dispData [NumWarps];

    // Pointers wrap explicitly at IbDepth, which need not be a power of two.
    function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    // Decode the single-warp event buses into per-warp strobes and build the
    // dispatch interface.  A dispatch with an empty FIFO can only be a
    // same-cycle bypass, in which case the decoded entry is neither stored nor
    // popped; in the default build that case never arises, so w_store reduces
    // to the decoder strobe and w_pop to the dispatch handshake.
    always_comb begin
        w_feHit      = '0;
        w_decHit     = '0;
        w_discHit    = '0;
        w_wbHit      = '0;
        w_canIssue   = '0;
        w_dispFire   = '0;
        w_store      = '0;
        w_pop        = '0;
        disp_valid_o = '0;
        disp_data_o  = '0;
        for (int w = 0; w < NumWarps; w++) begin
            w_feHit[w]    = fe_handshake_i && (fe_warp_id_i == WidWidth'(w));
            w_decHit[w]   = dec_valid_i && (dec_warp_id_i == WidWidth'(w));
            w_discHit[w]  = dec_discard_i && (dec_warp_id_i == WidWidth'(w));
            w_wbHit[w]    = wb_valid_i && (wb_warp_id_i == WidWidth'(w));
            w_canIssue[w] = r_inflight[w] < MaxInfVal;
`ifdef IB_BYPASS_EN
            disp_valid_o[w] = ((r_occ[w] != '0) || w_decHit[w]) && w_canIssue[w];
            w_dispData[w]   = (r_occ[w] == '0) ? dec_data_i : r_mem[w][r_rdPtr[w]];
`else
            disp_valid_o[w] = (r_occ[w] != '0) && w_canIssue[w];
            w_dispData[w]   = r_mem[w][r_rdPtr[w]];
`endif
            w_dispFire[w] = disp_valid_o[w] && disp_ready_i[w];
            w_pop[w]      = w_dispFire[w] && (r_occ[w] != '0);
            w_store[w]    = w_decHit[w] && !(w_dispFire[w] && (r_occ[w] == '0));
            if (disp_valid_o[w]) begin
                disp_data_o[w*DataWidth +: DataWidth] = w_dispData[w];
            end
        end
    end

    // Flow-control outputs come purely from registered counters, so the
    // fetcher sees a reservation one cycle after its handshake.
    always_comb begin
        ib_space_available_o    = '0;
        ib_all_instr_finished_o = '0;
        for (int w = 0; w < NumWarps; w++) begin
            ib_space_available_o[w] =
                ({1'b0, r_reserved[w]} + {1'b0, r_occ[w]}) < DepthVal;
            ib_all_instr_finished_o[w] =
                (r_reserved[w] == '0) && (r_occ[w] == '0) && (r_inflight[w] == '0);
        end
    end

    // Counter and pointer update.  Every event touching a warp contributes a
    // +1/-1 delta and all of them are summed in the same cycle, so coincident
    // events (e.g. reserve and decode together) cancel naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < NumWarps; w++) begin
                r_reserved[w] <= '0;
                r_occ[w]      <= '0;
                r_inflight[w] <= '0;
                r_rdPtr[w]    <= '0;
                r_wrPtr[w]    <= '0;
            end
        end else begin
            for (int w = 0; w < NumWarps; w++) begin
                r_reserved[w] <= r_reserved[w] + CntWidth'(w_feHit[w])
                                 - CntWidth'(w_decHit[w] | w_discHit[w]);
                r_occ[w]      <= r_occ[w] + CntWidth'(w_store[w])
                                 - CntWidth'(w_pop[w]);
                r_inflight[w] <= r_inflight[w] + InfWidth'(w_dispFire[w])
                                 - InfWidth'(w_wbHit[w]);
                if (w_store[w]) begin
                    r_wrPtr[w] <= nextPtr(r_wrPtr[w]);
                end
                if (w_pop[w]) begin
                    r_rdPtr[w] <= nextPtr(r_rdPtr[w]);
                end
            end
        end
    end

    // Payload storage carries no reset: an entry is only ever read after the
    // counters say it was written.
    always_ff @(posedge clk_i) begin
        for (int w = 0; w < NumWarps; w++) begin
            if (w_store[w]) begin
                r_mem[w][r_wrPtr[w]] <= dec_data_i;
            end
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on the neighbouring stages.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (fe_handshake_i) begin
                assert (ib_space_available_o[fe_warp_id_i])
                    else $error("instruction_buffer: fetch to warp %0d without space", fe_warp_id_i);
            end
            if (dec_valid_i || dec_discard_i) begin
                assert (r_reserved[dec_warp_id_i] != '0)
                    else $error("instruction_buffer: decode for warp %0d without reservation", dec_warp_id_i);
            end
            assert (!(dec_valid_i && dec_discard_i))
                else $error("instruction_buffer: dec_valid_i and dec_discard_i both high");
            if (wb_valid_i) begin
                assert (r_inflight[wb_warp_id_i] != '0)
                    else $error("instruction_buffer: writeback for warp %0d with nothing in flight", wb_warp_id_i);
            end
        end
    end
`endif

endmodule
